if_fetch_unit: RTL and testbench

- Instruction fetch stage of the 5-stage RV64 pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the 64-bit PC and issues one-outstanding-request fetches to a variable-latency instruction memory.
- Presents {pc_out, instruction, fetch_valid} to IF/ID, honours hazard-unit stalls (pc_write), and applies branch/jump redirects from the later stages.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/if_fetch_unit.sv | 75 +++++++
 tb/tb_if_fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
//   PC_W      - program counter width
//   NOP_INSTR - encoding of addi x0,x0,0, shown whenever no instruction is valid
//   state_t   - fetch controller states
package fetch_pkg;
    localparam int PC_W = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV64 IF stage, owns the PC and fetches one instruction at a time
//   clk, reset                 - clock, synchronous active-high reset
//   pc_write                   - 1 = consume presented instruction, 0 = stall
//   branch_taken/target        - redirect from later stages, highest priority
//   imem_req/addr/ready        - request channel (addr is the PC register)
//   imem_rvalid/rdata          - response channel
//   pc_out/instruction/valid   - registered outputs to the IF/ID register
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     instruction,
    output logic            fetch_valid
);
    state_t state, next_state;
    logic [PC_W-1:0] pc;
    logic capture, advance;

    always_ff @(posedge clk) begin
        if (reset) state <= S_REQ;
        else state <= next_state;
    end

    // A redirect retires or kills whatever is outstanding: an accepted but
    // unanswered request must be drained in S_DROP before a new one issues.
    always_comb begin
        next_state = state;
        case (state)
            S_REQ:  next_state = imem_ready ? (branch_taken ? S_DROP : S_WAIT) : S_REQ;
            S_WAIT: next_state = imem_rvalid ? (branch_taken ? S_REQ : S_HOLD)
                                             : (branch_taken ? S_DROP : S_WAIT);
            S_HOLD: next_state = (branch_taken || pc_write) ? S_REQ : S_HOLD;
            S_DROP: next_state = imem_rvalid ? S_REQ : S_DROP;
            default: next_state = S_REQ;
        endcase
    end

    assign imem_req  = (state == S_REQ) && !reset;
    assign imem_addr = pc;
    assign capture   = (state == S_WAIT) && imem_rvalid && !branch_taken;
    assign advance   = (state == S_HOLD) && pc_write && !branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            pc_out      <= '0;
            instruction <= NOP_INSTR;
            fetch_valid <= 1'b0;
        end else begin
            if (branch_taken) pc <= {branch_target[PC_W-1:2], 2'b00};
            else if (advance) pc <= pc + PC_W'(4);
            if (capture) pc_out <= pc;
            if (branch_taken || advance) begin
                instruction <= NOP_INSTR;
                fetch_valid <= 1'b0;
            end else if (capture) begin
                instruction <= imem_rdata;
                fetch_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed cycle table plus a zero-wait memory sequence for if_fetch_unit
module tb_if_fetch_unit;
    localparam logic [31:0] N = 32'h0000_0013;

    logic        clk = 0;
    logic        reset = 1;
    logic        pc_write = 0;
    logic        branch_taken = 0;
    logic [63:0] branch_target = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 0;
    logic        imem_rvalid = 0;
    logic [31:0] imem_rdata = '0;
    logic [63:0] pc_out;
    logic [31:0] instruction;
    logic        fetch_valid;

    int total = 0;
    int bad = 0;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_write(pc_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instruction(instruction), .fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pw, bt;
        logic [63:0] tgt;
        logic        rdy, rv;
        logic [31:0] rd;
        logic        e_req;
        logic [63:0] e_addr, e_pc;
        logic [31:0] e_ins;
        logic        e_fv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, pw, bt, input logic [63:0] tgt,
                       input logic rdy, rv, input logic [31:0] rd,
                       input logic e_req, input logic [63:0] e_addr, e_pc,
                       input logic [31:0] e_ins, input logic e_fv);
        vec_t v;
        v.rst = rst; v.pw = pw; v.bt = bt; v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_ins = e_ins; v.e_fv = e_fv;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [63:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    initial begin
        logic        pend;
        logic [63:0] paddr;
        int          nexp;
        // Each row: inputs for this cycle, outputs expected during this cycle.
        //  rst pw bt tgt                   rdy rv rd            req addr                  pc_out                ins            fv
        add(1, 0, 0, 0,                     0, 0, 0,             0, 0,                     0,                    N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             1, 0,                     0,                    N,             0);
        add(0, 1, 0, 0,                     1, 1, 32'hAAAA_0001, 0, 0,                     0,                    N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             0, 0,                     0,                    32'hAAAA_0001, 1);
        add(0, 1, 0, 0,                     1, 0, 0,             1, 64'h4,                 0,                    N,             0);
        add(0, 1, 0, 0,                     1, 1, 32'hAAAA_0002, 0, 64'h4,                 0,                    N,             0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0,                 1, 1, 32'hDEAD_BEEF, 0, 64'h4,                 64'h4,                32'hAAAA_0002, 1);
        add(0, 1, 0, 0,                     1, 0, 0,             0, 64'h4,                 64'h4,                32'hAAAA_0002, 1);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0,                 0, 0, 0,             1, 64'h8,                 64'h4,                N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             1, 64'h8,                 64'h4,                N,             0);
        add(0, 1, 1, 64'h103,               1, 0, 0,             0, 64'h8,                 64'h4,                N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             0, 64'h100,               64'h4,                N,             0);
        add(0, 1, 0, 0,                     1, 1, 32'hBBBB_0008, 0, 64'h100,               64'h4,                N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             1, 64'h100,               64'h4,                N,             0);
        add(0, 1, 0, 0,                     1, 1, 32'hAAAA_0100, 0, 64'h100,               64'h4,                N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             0, 64'h100,               64'h100,              32'hAAAA_0100, 1);
        add(0, 1, 0, 0,                     1, 0, 0,             1, 64'h104,               64'h100,              N,             0);
        add(0, 1, 1, 64'h200,               1, 1, 32'hBBBB_0104, 0, 64'h104,               64'h100,              N,             0);
        add(0, 1, 1, 64'h301,               1, 0, 0,             1, 64'h200,               64'h100,              N,             0);
        add(0, 1, 0, 0,                     1, 1, 32'hBBBB_0200, 0, 64'h300,               64'h100,              N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             1, 64'h300,               64'h100,              N,             0);
        add(0, 1, 0, 0,                     1, 1, 32'hAAAA_0300, 0, 64'h300,               64'h100,              N,             0);
        add(0, 0, 1, 64'h400,               1, 0, 0,             0, 64'h300,               64'h300,              32'hAAAA_0300, 1);
        add(0, 1, 1, 64'h500,               0, 0, 0,             1, 64'h400,               64'h300,              N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             1, 64'h500,               64'h300,              N,             0);
        add(1, 1, 0, 0,                     1, 1, 32'hBBBB_0500, 0, 64'h500,               64'h300,              N,             0);
        add(1, 1, 0, 0,                     1, 0, 0,             0, 0,                     0,                    N,             0);
        add(0, 1, 0, 0,                     0, 0, 0,             1, 0,                     0,                    N,             0);
        add(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0,           1, 0,                     0,                    N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             1, 64'hFFFF_FFFF_FFFF_FFFC, 0,                  N,             0);
        add(0, 1, 0, 0,                     1, 1, 32'hAAAA_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0,                  N,             0);
        add(0, 1, 0, 0,                     1, 0, 0,             0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 32'hAAAA_FFFC, 1);
        add(0, 1, 0, 0,                     0, 0, 0,             1, 0,                     64'hFFFF_FFFF_FFFF_FFFC, N,           0);

        repeat (2) @(posedge clk);
        foreach (tbl[k]) begin
            @(negedge clk);
            reset = tbl[k].rst; pc_write = tbl[k].pw; branch_taken = tbl[k].bt;
            branch_target = tbl[k].tgt; imem_ready = tbl[k].rdy;
            imem_rvalid = tbl[k].rv; imem_rdata = tbl[k].rd;
            #1;
            chk($sformatf("row%0d imem_req", k), 64'(imem_req), 64'(tbl[k].e_req));
            chk($sformatf("row%0d imem_addr", k), imem_addr, tbl[k].e_addr);
            chk($sformatf("row%0d pc_out", k), pc_out, tbl[k].e_pc);
            chk($sformatf("row%0d instruction", k), 64'(instruction), 64'(tbl[k].e_ins));
            chk($sformatf("row%0d fetch_valid", k), 64'(fetch_valid), 64'(tbl[k].e_fv));
        end

        // Zero-wait memory: accept immediately, answer the following cycle.
        @(negedge clk);
        reset = 1; branch_taken = 0; imem_ready = 0; imem_rvalid = 0; pc_write = 1;
        @(negedge clk);
        reset = 0;
        pend = 0; paddr = '0; nexp = 0;
        for (int c = 0; c < 40 && nexp < 3; c++) begin
            @(negedge clk);
            imem_ready = 1; imem_rvalid = pend; imem_rdata = pend ? mem(paddr) : 32'h0;
            #1;
            if (fetch_valid) begin
                chk($sformatf("stream pc_out #%0d", nexp), pc_out, 64'(nexp * 4));
                chk($sformatf("stream instr #%0d", nexp), 64'(instruction), 64'(mem(64'(nexp * 4))));
                nexp++;
            end else begin
                chk("stream nop between pulses", 64'(instruction), 64'(N));
            end
            pend = imem_req && imem_ready;
            if (pend) paddr = imem_addr;
        end
        chk("stream pulse count", 64'(nexp), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
